serial_pattern_tx: RTL
======================

# serial_pattern_tx

Serial bit-stream transmitter that produces the single-bit input stream `x` consumed by the team's two-bit Mealy sequence-detector (state `q1,q0`, input `x`, output `z`). It loads a parallel pattern, shifts it out MSB-first one bit per clock, and supports downstream back-pressure (`hold`), abort, and continuous looping. It sits between the stimulus/control logic and the detector's `x` input, replacing hand-written per-step stimulus with a clocked, repeatable source.

## Interface
Parameters:
- `WIDTH`, 8, pattern length in bits (≥2)
- `CW`, 4, width of the internal bit counter; must satisfy 2^CW > WIDTH

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `load`  in  1  capture `data` when `ready`=1
- `data`  in  WIDTH  pattern; bit WIDTH-1 transmitted first
- `loop`  in  1  sampled at last bit: 1 = restart the same pattern without returning to IDLE
- `hold`  in  1  downstream stall: freeze current bit, no shift
- `abort`  in  1  synchronous cancel; return to IDLE
- `ready`  out  1  block idle and accepting `load`
- `x`  out  1  current serial bit (0 when `x_valid`=0)
- `x_valid`  out  1  `x` carries a pattern bit this cycle
- `done`  out  1  one-cycle pulse after the final bit of a non-looping pattern
- `state`  out  2  FSM state: 00 IDLE, 01 SEND, 10 DONE

## Operation
- Registers: `sreg[WIDTH-1:0]` (shift register), `pat[WIDTH-1:0]` (copy for looping), `cnt[CW-1:0]` (bits remaining), 2-bit FSM.
- Reset (`rst_n`=0, asynchronous): state=IDLE, `sreg`=0, `pat`=0, `cnt`=0; outputs `ready`=1, `x`=0, `x_valid`=0, `done`=0, `state`=00.
- IDLE: `ready`=1. `load`=1 → `sreg`←`data`, `pat`←`data`, `cnt`←WIDTH, go to SEND. `hold` and `loop` are ignored.
- SEND: `x_valid`=1, `x`=`sreg[WIDTH-1]`, `ready`=0. `load` is ignored.
  - `hold`=1: registers unchanged; the same bit is re-presented next cycle.
  - `hold`=0, `cnt`>1: `sreg`←`sreg`<<1 (zero fill), `cnt`←`cnt`-1.
  - `hold`=0, `cnt`=1 (last bit): if `loop`=1 → `sreg`←`pat`, `cnt`←WIDTH, stay in SEND (no gap, no `done`); else go to DONE.
- DONE: `done`=1, `x_valid`=0, `ready`=0; next cycle unconditionally go to IDLE.
- `abort`=1 in any state has priority over `load`, `hold` and `loop`: next state IDLE, `cnt`←0, no `done` pulse. `abort` in IDLE has no effect.
- Outputs are a function of registered state only (Moore); there are no combinational paths from inputs to outputs.
- An invalid state encoding (11) recovers to IDLE on the next clock.

## Timing
- `load` sampled at edge N → `x_valid`=1 and first bit (`data[WIDTH-1]`) are visible after edge N.
- With `hold`=0 throughout: bit k (k=0 first) is valid in cycle N+1+k; the last bit is in cycle N+WIDTH; `done` is high in cycle N+WIDTH+1; `ready` returns in cycle N+WIDTH+2.
- Each `hold`=1 cycle in SEND adds exactly one cycle of latency and repeats the current bit.
- Loop: bit 0 of the next repetition immediately follows the last bit, with `x_valid` staying continuously high.
- Minimum load-to-load spacing without looping: WIDTH+2 cycles.
- `rst_n` asserted mid-transfer: outputs take reset values immediately (asynchronous), with no `done` pulse; the first `load` is accepted on the first edge after deassertion.

## Test plan
- Reset: drive `rst_n`=0 mid-SEND → `x_valid`=0, `x`=0, `done`=0, `ready`=1, `state`=00 before the next clock edge.
- Basic shift (WIDTH=8): load `8'b1011_0010`, hold=0 → `x`=1,0,1,1,0,0,1,0 on 8 consecutive cycles with `x_valid`=1; `done` high for exactly 1 cycle at load+9; `ready`=1 at load+10.
- Back-pressure: same pattern, `hold`=1 during bit 3 for 2 cycles → `x`=1,0,1,1,1,1,0,0,1,0; `done` at load+11.
- Abort: `abort` at bit 4 → `x_valid`=0 next cycle, no `done`, `ready`=1; a subsequent load of `8'hFF` gives eight 1s.
- Loop: load `8'b1100_0000`, `loop`=1 → 16 consecutive valid bits `11000000 11000000` with no gap; drop `loop` before the second last bit → `done` follows bit 16.
- Busy-load ignore: pulse `load` with `8'h55` during SEND of `8'hA5` → output is still `10100101`; `pat` is unchanged.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial pattern source for the sequence detector's x input: loads a parallel
// pattern and shifts it out MSB-first with hold, abort and loop support.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             loop,
  input  logic             hold,
  input  logic             abort,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sreg_r, sreg_s;
  logic [WIDTH-1:0] pat_r, pat_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             ready_r, x_r, x_valid_r, done_r;

  // Next-state and datapath update; abort overrides every other control.
  always_comb begin
    state_s = state_r;
    sreg_s  = sreg_r;
    pat_s   = pat_r;
    cnt_s   = cnt_r;
    if (abort) begin
      state_s = IDLE;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (load) begin
            sreg_s  = data;
            pat_s   = data;
            cnt_s   = CNT_FULL;
            state_s = SEND;
          end else begin
            state_s = IDLE;
          end
        end
        SEND: begin
          if (hold) begin
            state_s = SEND;
          end else if (cnt_r > CNT_ONE) begin
            sreg_s = {sreg_r[WIDTH-2:0], 1'b0};
            cnt_s  = cnt_r - CNT_ONE;
          end else if (loop) begin
            sreg_s = pat_r;
            cnt_s  = CNT_FULL;
          end else begin
            state_s = DONE;
            cnt_s   = CNT_ZERO;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          // Unused encoding 11 falls back to a clean idle.
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State registers; outputs are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      sreg_r    <= {WIDTH{1'b0}};
      pat_r     <= {WIDTH{1'b0}};
      cnt_r     <= CNT_ZERO;
      ready_r   <= 1'b1;
      x_r       <= 1'b0;
      x_valid_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      sreg_r    <= sreg_s;
      pat_r     <= pat_s;
      cnt_r     <= cnt_s;
      ready_r   <= (state_s == IDLE);
      x_valid_r <= (state_s == SEND);
      x_r       <= (state_s == SEND) ? sreg_s[WIDTH-1] : 1'b0;
      done_r    <= (state_s == DONE);
    end
  end

  assign ready   = ready_r;
  assign x       = x_r;
  assign x_valid = x_valid_r;
  assign done    = done_r;
  assign state   = state_r;

endmodule
